axi_lite_user_dispatcher: RTL and testbench
===========================================

Name: axi_lite_user_dispatcher

Overview:
- Sits on the user side of the AXI-Lite slave FIFO bridge.
- Consumes the bridge's command channel (user_addr, read/write enables) and routes each command to one of NUM_TARGETS register-bank targets, selected by the top address bits.
- Moves write data out of the bridge write FIFO and read data into the bridge read FIFO.
- Serialises commands, enforces a per-access timeout, and always returns read data so the AXI side can never hang.

Parameters:
- USER_ADDR_WIDTH, 8: width of user_addr.
- DATA_WIDTH, 32: data width.
- SEL_WIDTH, 2: target-select bits, user_addr[USER_ADDR_WIDTH-1 -: SEL_WIDTH]. NUM_TARGETS = 2**SEL_WIDTH.
- TIMEOUT, 255: maximum cycles tgt_req is held without tgt_ack. Range 1..65535.
- TIMEOUT_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous active-high reset.
- user_addr  in  USER_ADDR_WIDTH  command address.
- user_read_enable  in  1  read command pulse.
- user_write_enable  in  1  write command pulse.
- user_ready  out  1  busy/ack flag; high while a command is in flight. The bridge issues commands only while it is low.
- user_write_deq  out  1  pop the bridge write FIFO.
- user_write_data  in  DATA_WIDTH  write FIFO head.
- user_write_empty  in  1  write FIFO empty.
- user_read_enq  out  1  push the bridge read FIFO.
- user_read_data  out  DATA_WIDTH  read FIFO push data.
- user_read_almost_full  in  1  read FIFO almost full.
- tgt_req  out  NUM_TARGETS  one-hot request.
- tgt_we  out  1  1 = write, 0 = read.
- tgt_addr  out  USER_ADDR_WIDTH-SEL_WIDTH  local address.
- tgt_wdata  out  DATA_WIDTH  write data.
- tgt_ack  in  NUM_TARGETS  per-target acknowledge.
- tgt_rdata  in  NUM_TARGETS*DATA_WIDTH  flattened read data; target i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ERROR  out  1  sticky error flag.
- timeout_count  out  8  saturating count of timeouts.

Behaviour:
- Reset: ARESET asynchronously clears every register. All outputs are 0 and the state is IDLE. Reset asserted mid-operation abandons the command immediately; no FIFO push or pop occurs after ARESET rises.
- All outputs are registered except user_write_deq. user_write_deq is combinational: (state==WDATA) && !user_write_empty.

FSM:
- IDLE:
  - user_read_enable: latch sel/addr, tgt_we<=0, user_ready<=1 (visible the next cycle), go to REQ.
  - user_write_enable: latch sel/addr, tgt_we<=1, user_ready<=1, go to WDATA.
  - Both enables in the same cycle: read wins and ERROR is set.
- WDATA:
  - Wait for !user_write_empty.
  - In that cycle, user_write_deq=1 and tgt_wdata<=user_write_data; next state REQ.
- REQ:
  - tgt_req[sel]=1 and the timeout counter increments every cycle.
  - On tgt_ack[sel] (sampled while req is high): tgt_req<=0.
    - Read: capture tgt_rdata slice, go to RESP.
    - Write: go to DONE.
  - Acks from other targets are ignored.
  - When the counter reaches TIMEOUT with no ack: drop req, ERROR<=1, timeout_count++ (saturates at 255).
    - Read: load TIMEOUT_DATA, go to RESP.
    - Write: discard the data, go to DONE.
  - An ack in the same cycle as the timeout counts as an ack.
- RESP: wait for !user_read_almost_full, then user_read_enq=1 for one cycle with user_read_data = the captured data; go to DONE.
- DONE: user_ready<=0, go to IDLE. A new command is accepted no earlier than the cycle after user_ready falls.

Handshakes and errors:
- Any enable pulse seen outside IDLE is ignored and sets ERROR.
- Exactly one FIFO pop per write and exactly one FIFO push per read.
- ERROR clears only on reset.

Latency (zero-wait target, FIFOs ready):
- Read: enable to user_read_enq = 4 cycles.
- Write: enable to tgt_req = 2 cycles.

Test Plan:
- Read, target 2, addr 8'h85: tgt_ack the cycle after req with rdata 32'h1234_5678 -> tgt_req=4'b0100, tgt_addr=6'h05, tgt_we=0; one user_read_enq with 32'h1234_5678; user_ready high exactly 4 cycles; ERROR=0.
- Write, addr 8'hC3, write FIFO empty for 5 cycles, then data 32'hA5A5_0001 -> no tgt_req while empty; exactly one user_write_deq; tgt_req=4'b1000, tgt_wdata=32'hA5A5_0001, tgt_addr=6'h03.
- Read, target 1, TIMEOUT=4, no ack -> req held exactly 4 cycles; user_read_enq with 32'hDEAD_BEEF; ERROR=1; timeout_count=1.
- Read with user_read_almost_full held for 10 cycles after ack -> user_read_enq is delayed until it deasserts, then a single push with the correct data.
- Reads and writes back-to-back, 20 random commands across all targets, plus stray tgt_ack on unselected targets -> order preserved; stray acks ignored; enable while busy sets ERROR and produces no extra FIFO activity.
- ARESET asserted mid-REQ -> tgt_req, user_ready and user_read_enq go to 0 asynchronously; after release the FSM is in IDLE and accepts a new read normally.

Source files
------------

// File: rtl/axi_lite_user_dispatcher.sv
// User-side command dispatcher for the AXI-Lite slave FIFO bridge: routes each command
// to one register-bank target, bounds every access with a timeout, always answers reads.
module axi_lite_user_dispatcher #(
    parameter int                    USER_ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    SEL_WIDTH       = 2,
    parameter int                    TIMEOUT         = 255,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA    = 32'hDEAD_BEEF,
    localparam int                   NUM_TARGETS     = 2 ** SEL_WIDTH,
    localparam int                   LOCAL_WIDTH     = USER_ADDR_WIDTH - SEL_WIDTH
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [USER_ADDR_WIDTH-1:0]        user_addr,
    input  logic                              user_read_enable,
    input  logic                              user_write_enable,
    output logic                              user_ready,
    output logic                              user_write_deq,
    input  logic [DATA_WIDTH-1:0]             user_write_data,
    input  logic                              user_write_empty,
    output logic                              user_read_enq,
    output logic [DATA_WIDTH-1:0]             user_read_data,
    input  logic                              user_read_almost_full,
    output logic [NUM_TARGETS-1:0]            tgt_req,
    output logic                              tgt_we,
    output logic [LOCAL_WIDTH-1:0]            tgt_addr,
    output logic [DATA_WIDTH-1:0]             tgt_wdata,
    input  logic [NUM_TARGETS-1:0]            tgt_ack,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] tgt_rdata,
    output logic                              ERROR,
    output logic [7:0]                        timeout_count
);

    typedef enum logic [2:0] {IDLE, WDATA, REQ, RESP, DONE} state_t;

    state_t                   state_q, state_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [LOCAL_WIDTH-1:0]   addr_q, addr_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [NUM_TARGETS-1:0]   req_q, req_d;
    logic                     ready_q, ready_d;
    logic                     enq_q, enq_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     error_q, error_d;
    logic [7:0]               tcount_q, tcount_d;
    logic [15:0]              cnt_q, cnt_d;

    logic [SEL_WIDTH-1:0]     cmd_sel;
    logic [NUM_TARGETS-1:0]   cmd_onehot;
    logic [NUM_TARGETS-1:0]   sel_onehot;

    assign cmd_sel    = user_addr[USER_ADDR_WIDTH-1 -: SEL_WIDTH];
    assign cmd_onehot = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << cmd_sel;
    assign sel_onehot = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << sel_q;

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no branch infers a latch.
        state_d        = state_q;
        sel_d          = sel_q;
        addr_d         = addr_q;
        we_d           = we_q;
        wdata_d        = wdata_q;
        req_d          = req_q;
        ready_d        = ready_q;
        enq_d          = 1'b0;
        rdata_d        = rdata_q;
        error_d        = error_q;
        tcount_d       = tcount_q;
        cnt_d          = cnt_q;
        user_write_deq = 1'b0;

        // The bridge must hold off while a command is in flight; a pulse here is a protocol error.
        if (state_q != IDLE && (user_read_enable || user_write_enable))
            error_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (user_read_enable || user_write_enable) begin
                    sel_d   = cmd_sel;
                    addr_d  = user_addr[LOCAL_WIDTH-1:0];
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    if (user_read_enable) begin
                        we_d    = 1'b0;
                        req_d   = cmd_onehot;
                        state_d = REQ;
                        if (user_write_enable)
                            error_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (!user_write_empty) begin
                    user_write_deq = 1'b1;
                    wdata_d        = user_write_data;
                    req_d          = sel_onehot;
                    cnt_d          = '0;
                    state_d        = REQ;
                end
            end
            REQ: begin
                // An ack landing on the timeout cycle still completes the access normally.
                if (tgt_ack[sel_q]) begin
                    req_d = '0;
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        rdata_d = tgt_rdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
                        state_d = RESP;
                    end
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    req_d   = '0;
                    error_d = 1'b1;
                    if (tcount_q != 8'hFF)
                        tcount_d = tcount_q + 8'd1;
                    if (we_q) begin
                        state_d = DONE;
                    end else begin
                        rdata_d = TIMEOUT_DATA;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                if (!user_read_almost_full) begin
                    enq_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            req_q    <= '0;
            ready_q  <= 1'b0;
            enq_q    <= 1'b0;
            rdata_q  <= '0;
            error_q  <= 1'b0;
            tcount_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            ready_q  <= ready_d;
            enq_q    <= enq_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
            tcount_q <= tcount_d;
            cnt_q    <= cnt_d;
        end
    end

    assign user_ready     = ready_q;
    assign user_read_enq  = enq_q;
    assign user_read_data = rdata_q;
    assign tgt_req        = req_q;
    assign tgt_we         = we_q;
    assign tgt_addr       = addr_q;
    assign tgt_wdata      = wdata_q;
    assign ERROR          = error_q;
    assign timeout_count  = tcount_q;

endmodule

// File: tb/tb_axi_lite_user_dispatcher.sv
// Directed + random bench for axi_lite_user_dispatcher; target banks and bridge FIFOs are
// modelled here, expected commands and read pushes are queued and checked as they appear.
module tb_axi_lite_user_dispatcher;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NT = 4;
    localparam int LW = 6;
    localparam int TO = 4;

    typedef struct packed {
        logic [NT-1:0] req;
        logic          we;
        logic [LW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic             ACLK = 1'b0;
    logic             ARESET = 1'b1;
    logic [AW-1:0]    user_addr;
    logic             user_read_enable;
    logic             user_write_enable;
    logic             user_ready;
    logic             user_write_deq;
    logic [DW-1:0]    user_write_data;
    logic             user_write_empty;
    logic             user_read_enq;
    logic [DW-1:0]    user_read_data;
    logic             user_read_almost_full;
    logic [NT-1:0]    tgt_req;
    logic             tgt_we;
    logic [LW-1:0]    tgt_addr;
    logic [DW-1:0]    tgt_wdata;
    logic [NT-1:0]    tgt_ack = '0;
    logic [NT*DW-1:0] tgt_rdata;
    logic             ERROR;
    logic [7:0]       timeout_count;

    axi_lite_user_dispatcher #(
        .USER_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(2),
        .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEAD_BEEF)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .user_addr(user_addr), .user_read_enable(user_read_enable),
        .user_write_enable(user_write_enable), .user_ready(user_ready),
        .user_write_deq(user_write_deq), .user_write_data(user_write_data),
        .user_write_empty(user_write_empty), .user_read_enq(user_read_enq),
        .user_read_data(user_read_data), .user_read_almost_full(user_read_almost_full),
        .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_ack(tgt_ack), .tgt_rdata(tgt_rdata), .ERROR(ERROR), .timeout_count(timeout_count)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Target banks: ack after ack_dly cycles of req, rdata valid only alongside a real ack.
    logic [DW-1:0] rdata_val [NT];
    logic [NT-1:0] ack_en = '1;
    logic [NT-1:0] stray_ack = '0;
    logic [NT-1:0] real_ack = '0;
    int            ack_dly = 2;
    int            hi_cnt [NT];

    always @(posedge ACLK) begin
        #1;
        for (int i = 0; i < NT; i++) begin
            if (tgt_req[i]) hi_cnt[i] = hi_cnt[i] + 1;
            else            hi_cnt[i] = 0;
            real_ack[i] = tgt_req[i] && ack_en[i] && (hi_cnt[i] >= ack_dly);
            tgt_rdata[i*DW +: DW] = real_ack[i] ? rdata_val[i] : (32'hBAD0_0000 | 32'(i));
        end
        tgt_ack = real_ack | stray_ack;
    end

    // Scoreboard and activity monitor.
    cmd_t          cmd_q [$];
    logic [DW-1:0] rd_q [$];
    cmd_t          mon_e;
    logic [DW-1:0] mon_d;
    logic [NT-1:0] prev_req = '0;
    int req_rise_cnt = 0, req_rise_cyc = 0, req_len = 0, last_req_len = 0;
    int ready_len = 0, last_ready_len = 0;
    int enq_cnt = 0, enq_cyc = 0, deq_cnt = 0;
    int cmd_cyc = 0;

    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (tgt_req != '0 && prev_req == '0) begin
                req_rise_cnt++;
                req_rise_cyc = cyc;
                check("req_expected", 64'(cmd_q.size() != 0), 64'd1);
                if (cmd_q.size() != 0) begin
                    mon_e = cmd_q.pop_front();
                    check("cmd_req", 64'(tgt_req), 64'(mon_e.req));
                    check("cmd_addr", 64'(tgt_addr), 64'(mon_e.addr));
                    check("cmd_we", 64'(tgt_we), 64'(mon_e.we));
                    if (mon_e.we) check("cmd_wdata", 64'(tgt_wdata), 64'(mon_e.wdata));
                end
            end
            if (tgt_req != '0) req_len++;
            else if (req_len != 0) begin last_req_len = req_len; req_len = 0; end
            if (user_ready) ready_len++;
            else if (ready_len != 0) begin last_ready_len = ready_len; ready_len = 0; end
            if (user_read_enq) begin
                enq_cnt++;
                enq_cyc = cyc;
                check("push_expected", 64'(rd_q.size() != 0), 64'd1);
                if (rd_q.size() != 0) begin
                    mon_d = rd_q.pop_front();
                    check("push_data", 64'(user_read_data), 64'(mon_d));
                end
            end
            if (user_write_deq) deq_cnt++;
        end else begin
            req_len   = 0;
            ready_len = 0;
        end
        prev_req = tgt_req;
    end

    task automatic push_cmd(input logic [NT-1:0] req, input logic we, input logic [LW-1:0] a,
                            input logic [DW-1:0] d);
        cmd_t c;
        c.req = req; c.we = we; c.addr = a; c.wdata = d;
        cmd_q.push_back(c);
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a);
        @(posedge ACLK); #1;
        user_addr = a; user_read_enable = rd; user_write_enable = wr;
        cmd_cyc = cyc;
        @(posedge ACLK); #1;
        user_read_enable = 1'b0; user_write_enable = 1'b0;
    endtask

    task automatic write_cmd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        user_write_data  = d;
        user_write_empty = 1'b0;
        issue(1'b0, 1'b1, a);
        @(posedge ACLK); #1;
        user_write_empty = 1'b1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        int n = 0;
        while (!ok && n < 60) begin
            @(negedge ACLK); #1;
            ok = !user_ready;
            n++;
        end
        if (!ok) check("wait_idle_bound", 64'd0, 64'd1);
    endtask

    task automatic wait_req(input logic active, input string tag);
        bit ok = 0;
        int n = 0;
        while (!ok && n < 60) begin
            @(negedge ACLK); #1;
            ok = ((tgt_req != '0) == active);
            n++;
        end
        if (!ok) check(tag, 64'd0, 64'd1);
    endtask

    task automatic pulse_reset();
        @(posedge ACLK); #1; ARESET = 1'b1;
        @(posedge ACLK); #1; ARESET = 1'b0;
    endtask

    int enq0, deq0, rise0, n_rd, n_wr, r_t;
    logic          r_w;
    logic [LW-1:0] r_a;
    logic [DW-1:0] r_d;
    logic [NT-1:0] r_oh;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        user_addr = '0; user_read_enable = 0; user_write_enable = 0;
        user_write_data = '0; user_write_empty = 1; user_read_almost_full = 0;
        for (int i = 0; i < NT; i++) rdata_val[i] = '0;

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_req", 64'(tgt_req), 64'd0);
        check("rst_ready", 64'(user_ready), 64'd0);
        check("rst_enq", 64'(user_read_enq), 64'd0);
        check("rst_deq", 64'(user_write_deq), 64'd0);
        check("rst_error", 64'(ERROR), 64'd0);
        check("rst_tcount", 64'(timeout_count), 64'd0);
        check("rst_we", 64'(tgt_we), 64'd0);
        check("rst_rdata", 64'(user_read_data), 64'd0);
        @(posedge ACLK); #1; ARESET = 1'b0;

        // Read target 2, zero-wait bank
        rdata_val[2] = 32'h1234_5678;
        push_cmd(4'b0100, 1'b0, 6'h05, '0);
        rd_q.push_back(32'h1234_5678);
        enq0 = enq_cnt;
        issue(1'b1, 1'b0, 8'h85);
        wait_idle();
        check("t1_enq_count", 64'(enq_cnt - enq0), 64'd1);
        check("t1_latency", 64'(enq_cyc - cmd_cyc), 64'd4);
        check("t1_ready_len", 64'(last_ready_len), 64'd4);
        check("t1_error", 64'(ERROR), 64'd0);

        // Write target 3 with the write FIFO empty for 5 cycles
        user_write_empty = 1'b1;
        user_write_data  = 32'hA5A5_0001;
        push_cmd(4'b1000, 1'b1, 6'h03, 32'hA5A5_0001);
        deq0 = deq_cnt; rise0 = req_rise_cnt;
        issue(1'b0, 1'b1, 8'hC3);
        repeat (4) @(posedge ACLK);
        #1;
        check("t2_req_while_empty", 64'(tgt_req), 64'd0);
        check("t2_rise_while_empty", 64'(req_rise_cnt - rise0), 64'd0);
        check("t2_deq_while_empty", 64'(deq_cnt - deq0), 64'd0);
        user_write_empty = 1'b0;
        @(posedge ACLK); #1;
        user_write_empty = 1'b1;
        wait_idle();
        check("t2_deq_count", 64'(deq_cnt - deq0), 64'd1);
        check("t2_rise_count", 64'(req_rise_cnt - rise0), 64'd1);

        // Write with data ready: enable to tgt_req latency
        push_cmd(4'b0010, 1'b1, 6'h01, 32'h5A5A_0002);
        deq0 = deq_cnt;
        write_cmd(8'h41, 32'h5A5A_0002);
        wait_idle();
        check("wr_latency", 64'(req_rise_cyc - cmd_cyc), 64'd2);
        check("wr_deq_count", 64'(deq_cnt - deq0), 64'd1);

        // Read with the read FIFO almost full for 10 cycles after the ack
        rdata_val[0] = 32'hCAFE_0004;
        push_cmd(4'b0001, 1'b0, 6'h07, '0);
        rd_q.push_back(32'hCAFE_0004);
        user_read_almost_full = 1'b1;
        enq0 = enq_cnt;
        issue(1'b1, 1'b0, 8'h07);
        wait_req(1'b0, "t4_req_fall_bound");
        repeat (10) @(posedge ACLK);
        #1;
        check("t4_enq_held", 64'(enq_cnt - enq0), 64'd0);
        user_read_almost_full = 1'b0;
        wait_idle();
        check("t4_enq_count", 64'(enq_cnt - enq0), 64'd1);
        check("t4_error", 64'(ERROR), 64'd0);

        // Timeout on target 1
        pulse_reset();
        ack_en[1] = 1'b0;
        push_cmd(4'b0010, 1'b0, 6'h0A, '0);
        rd_q.push_back(32'hDEAD_BEEF);
        enq0 = enq_cnt;
        issue(1'b1, 1'b0, 8'h4A);
        wait_idle();
        ack_en[1] = 1'b1;
        check("to_req_len", 64'(last_req_len), 64'(TO));
        check("to_error", 64'(ERROR), 64'd1);
        check("to_tcount", 64'(timeout_count), 64'd1);
        check("to_enq_count", 64'(enq_cnt - enq0), 64'd1);

        // Both enables at once: read wins, no FIFO pop
        pulse_reset();
        check("post_rst_tcount", 64'(timeout_count), 64'd0);
        rdata_val[0] = 32'h0B07_0012;
        push_cmd(4'b0001, 1'b0, 6'h12, '0);
        rd_q.push_back(32'h0B07_0012);
        user_write_empty = 1'b0; user_write_data = 32'hFFFF_0000;
        deq0 = deq_cnt; enq0 = enq_cnt;
        issue(1'b1, 1'b1, 8'h12);
        wait_idle();
        user_write_empty = 1'b1;
        check("both_deq", 64'(deq_cnt - deq0), 64'd0);
        check("both_enq", 64'(enq_cnt - enq0), 64'd1);
        check("both_error", 64'(ERROR), 64'd1);

        // Enables while busy are ignored but flagged
        pulse_reset();
        check("busy_error_before", 64'(ERROR), 64'd0);
        rdata_val[3] = 32'h3333_C009;
        push_cmd(4'b1000, 1'b0, 6'h09, '0);
        rd_q.push_back(32'h3333_C009);
        user_write_empty = 1'b0;
        deq0 = deq_cnt; enq0 = enq_cnt; rise0 = req_rise_cnt;
        issue(1'b1, 1'b0, 8'hC9);
        user_addr = 8'h01; user_write_enable = 1'b1;
        @(posedge ACLK); #1;
        user_write_enable = 1'b0; user_read_enable = 1'b1;
        @(posedge ACLK); #1;
        user_read_enable = 1'b0;
        wait_idle();
        user_write_empty = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check("busy_error", 64'(ERROR), 64'd1);
        check("busy_deq", 64'(deq_cnt - deq0), 64'd0);
        check("busy_enq", 64'(enq_cnt - enq0), 64'd1);
        check("busy_rise", 64'(req_rise_cnt - rise0), 64'd1);

        // 20 random back-to-back commands with stray acks
        n_rd = 0; n_wr = 0;
        deq0 = deq_cnt; enq0 = enq_cnt;
        for (int n = 0; n < 20; n++) begin
            r_t  = int'($urandom_range(0, NT - 1));
            r_w  = 1'($urandom_range(0, 1));
            r_a  = 6'($urandom);
            r_d  = $urandom;
            r_oh = 4'b0001 << r_t;
            ack_dly   = int'($urandom_range(2, TO));
            stray_ack = 4'($urandom) & ~r_oh;
            if (r_w) begin
                push_cmd(r_oh, 1'b1, r_a, r_d);
                write_cmd({2'(r_t), r_a}, r_d);
                n_wr++;
            end else begin
                rdata_val[r_t] = r_d;
                push_cmd(r_oh, 1'b0, r_a, '0);
                rd_q.push_back(r_d);
                issue(1'b1, 1'b0, {2'(r_t), r_a});
                n_rd++;
            end
            wait_idle();
            stray_ack = '0;
        end
        ack_dly = 2;
        check("rand_deq_count", 64'(deq_cnt - deq0), 64'(n_wr));
        check("rand_enq_count", 64'(enq_cnt - enq0), 64'(n_rd));
        check("rand_tcount", 64'(timeout_count), 64'd0);

        // Reset asserted mid-REQ
        ack_en[2] = 1'b0;
        push_cmd(4'b0100, 1'b0, 6'h11, '0);
        rd_q.push_back(32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 8'h91);
        check("mid_req_active", 64'(tgt_req), 64'b0100);
        @(negedge ACLK); #2;
        ARESET = 1'b1;
        #1;
        check("mid_rst_req", 64'(tgt_req), 64'd0);
        check("mid_rst_ready", 64'(user_ready), 64'd0);
        check("mid_rst_enq", 64'(user_read_enq), 64'd0);
        check("mid_rst_error", 64'(ERROR), 64'd0);
        cmd_q.delete();
        rd_q.delete();
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        ack_en[2] = 1'b1;
        rdata_val[2] = 32'h7777_0092;
        push_cmd(4'b0100, 1'b0, 6'h12, '0);
        rd_q.push_back(32'h7777_0092);
        enq0 = enq_cnt;
        issue(1'b1, 1'b0, 8'h92);
        wait_idle();
        check("post_rst_enq", 64'(enq_cnt - enq0), 64'd1);
        check("post_rst_ready_len", 64'(last_ready_len), 64'd4);

        check("cmd_q_drained", 64'(cmd_q.size()), 64'd0);
        check("rd_q_drained", 64'(rd_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
